dbg_access_ctrl: RTL and testbench
==================================

// Module: dbg_access_ctrl
// PURPOSE
//  Parametrised debug access controller between the external debug port and the rv32i core.
//  Accepts one command at a time over a valid/ready handshake and reads PC, icache, regfile or dcache.
//  Writes icache (and dcache when compiled in). Reads may be multi-beat bursts with address auto-increment.
//  Returns each beat over a valid/ready response channel. Drives the active-low SRAM strobes and the regfile read port.
// PARAMETERS
//  DATA_W   32  data width of caches, regfile, PC and response
//  IADDR_W  10  icache word-address width
//  DADDR_W  10  dcache word-address width
//  RADDR_W  5   regfile address width
//  MEM_LAT  1   SRAM read latency in cycles, from strobe cycle to data valid (>=1)
//  BURST_W  4   width of cmd_len; beats = cmd_len+1
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        asynchronous reset, active low
//  cmd_valid       in   1        command valid
//  cmd_ready       out  1        command accepted when valid&ready
//  cmd_op          in   3        0 PCRD, 1 ICRD, 2 ICWR, 3 REGRD, 4 DCRD, 5 DCWR, 6-7 illegal
//  cmd_addr        in   DATA_W   start word address; low IADDR_W/DADDR_W/RADDR_W bits used
//  cmd_len         in   BURST_W  beats-1; reads only
//  cmd_wdata       in   DATA_W   write data
//  rsp_valid       out  1        response beat valid
//  rsp_ready       in   1        response beat consumed when valid&ready
//  rsp_data        out  DATA_W   read data; 0 for writes and errors
//  rsp_last        out  1        final beat of the command
//  rsp_err         out  1        illegal or disabled op
//  pc_i            in   DATA_W   current PC
//  icache_rdata_i  in   DATA_W   icache read data
//  reg_rdata_i     in   DATA_W   regfile port-2 read data (combinational)
//  dcache_rdata_i  in   DATA_W   dcache read data
//  icache_addr_o   out  IADDR_W  icache address
//  icache_ceb_o    out  1        icache chip enable, active low
//  icache_web_o    out  1        icache write enable, active low
//  icache_wdata_o  out  DATA_W   icache write data
//  reg_raddr_o     out  RADDR_W  regfile port-2 read address
//  reg_read_o      out  1        regfile debug read enable, active high
//  dcache_addr_o   out  DADDR_W  dcache address
//  dcache_ceb_o    out  1        dcache chip enable, active low
//  dcache_bweb_o   out  DATA_W   dcache bit write enable, active low
//  dcache_wdata_o  out  DATA_W   dcache write data
//  busy_o          out  1        high whenever the FSM is not IDLE
// BEHAVIOUR
//  - Reset (async, any state): FSM to IDLE; any in-flight burst is dropped without a response.
//  - Reset output values: cmd_ready=1 once released; rsp_valid/rsp_last/rsp_err=0; rsp_data=0;
//    all addr/wdata outputs 0; ceb/web=1; bweb all ones; reg_read_o=0; busy_o=0.
//  - All outputs are registered.
//  - FSM states: IDLE -> ISSUE -> WAIT -> RESP.
//  - IDLE: cmd_ready=1. On handshake, capture op, addr, len and wdata, then go to ISSUE.
//  - ISSUE (1 cycle): strobes for the current beat are low for exactly this cycle.
//    ICRD/DCRD: assert ceb only. ICWR: assert ceb and web. DCWR: assert ceb and bweb all zero.
//    REGRD: reg_read_o=1 and reg_raddr_o driven. PCRD: no strobes.
//  - ISSUE exit: ICRD/DCRD go to WAIT. All other ops go straight to RESP.
//    For REGRD and PCRD, reg_rdata_i or pc_i is sampled at the end of ISSUE.
//  - WAIT: lasts MEM_LAT cycles. cache rdata is sampled at the end of its last cycle. Then RESP.
//  - RESP: rsp_valid=1. rsp_data, rsp_last and rsp_err stay stable until rsp_ready.
//    On handshake: if more beats remain, go to ISSUE with address+1; else go to IDLE.
//  - Read latency, cmd handshake to rsp_valid: cache reads 1+MEM_LAT cycles; REGRD/PCRD 1 cycle.
//  - Burst rules:
//    address wraps modulo 2^IADDR_W, 2^DADDR_W or 2^RADDR_W per target;
//    PCRD and all writes are single-beat with rsp_last=1 (cmd_len ignored);
//    for reads, rsp_last=1 only on beat cmd_len+1.
//  - Error rules: op 6/7 (and op 5 when the feature is out) go ISSUE->RESP with no strobes,
//    rsp_err=1, rsp_last=1, rsp_data=0.
//  - Back-pressure: the next beat is not issued until the current beat is consumed,
//    so at most one beat is in flight.
//  - cmd_valid is ignored outside IDLE.
// CONFIGURATION
//  DBG_DCACHE_WR_EN defined: op 5 (DCWR) writes cmd_wdata to the dcache;
//    dcache_wdata_o follows the captured data.
//  DBG_DCACHE_WR_EN undefined: op 5 returns rsp_err=1; dcache_bweb_o is tied to all ones;
//    dcache_wdata_o is tied to 0.
// TESTING
//  - ICWR addr=0x3 wdata=0xDEADBEEF -> one ISSUE cycle with ceb=0, web=0, addr=3;
//    rsp_last=1, rsp_err=0, rsp_data=0.
//  - ICRD addr=0x3FE len=3, MEM_LAT=2 -> addresses 3FE,3FF,000,001;
//    first rsp_valid 3 cycles after accept; rsp_last only on beat 4.
//  - REGRD addr=5 len=0 with rsp_ready held low for 4 cycles ->
//    rsp_data=reg_rdata_i stays stable; no new strobe until rsp_ready.
//  - DCWR addr=7 wdata=0x12345678 -> with macro: bweb=0 for one cycle, rsp_err=0;
//    without macro: no strobe, rsp_err=1.
//  - cmd_op=7 -> rsp_err=1, rsp_last=1, all strobes idle;
//    PCRD with pc_i=0x100 -> rsp_data=0x100 one cycle after accept.
//  - rst_n low during beat 2 of a len=5 DCRD -> outputs return to reset values immediately;
//    next command completes normally.

Source files
------------

// File: rtl/dbg_access_ctrl.sv
// rtl/dbg_access_ctrl.sv - debug access controller between the debug port and the rv32i core
//
// Accepts one command at a time (cmd_* valid/ready) and returns one response beat
// at a time (rsp_* valid/ready). Reads PC, icache, regfile or dcache, with optional
// multi-beat bursts and per-target address wrap. Writes icache and, when built with
// DBG_DCACHE_WR_EN, dcache. Every output comes from a flop.
//
// Build option:
//   DBG_DCACHE_WR_EN  defined   : op 5 (DCWR) writes cmd_wdata to the dcache
//                     undefined : op 5 returns rsp_err, dcache_bweb_o/dcache_wdata_o tied off
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_len/cmd_wdata   command channel
//   rsp_valid/rsp_ready/rsp_data/rsp_last/rsp_err           response channel
//   pc_i, icache_rdata_i, reg_rdata_i, dcache_rdata_i       read data from the core
//   icache_addr_o/ceb_o/web_o/wdata_o                       icache SRAM port (active-low strobes)
//   reg_raddr_o/reg_read_o                                  regfile port-2 read
//   dcache_addr_o/ceb_o/bweb_o/wdata_o                      dcache SRAM port (active-low strobes)
//   busy_o                                                  FSM not idle
module dbg_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 10,
  parameter int RADDR_W = 5,
  parameter int MEM_LAT = 1,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_addr,
  input  logic [BURST_W-1:0] cmd_len,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_last,
  output logic               rsp_err,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [DATA_W-1:0]  icache_rdata_i,
  input  logic [DATA_W-1:0]  reg_rdata_i,
  input  logic [DATA_W-1:0]  dcache_rdata_i,
  output logic [IADDR_W-1:0] icache_addr_o,
  output logic               icache_ceb_o,
  output logic               icache_web_o,
  output logic [DATA_W-1:0]  icache_wdata_o,
  output logic [RADDR_W-1:0] reg_raddr_o,
  output logic               reg_read_o,
  output logic [DADDR_W-1:0] dcache_addr_o,
  output logic               dcache_ceb_o,
  output logic [DATA_W-1:0]  dcache_bweb_o,
  output logic [DATA_W-1:0]  dcache_wdata_o,
  output logic               busy_o
);

  localparam logic [2:0] OP_PCRD  = 3'd0;
  localparam logic [2:0] OP_ICRD  = 3'd1;
  localparam logic [2:0] OP_ICWR  = 3'd2;
  localparam logic [2:0] OP_REGRD = 3'd3;
  localparam logic [2:0] OP_DCRD  = 3'd4;
  localparam logic [2:0] OP_DCWR  = 3'd5;

  // Beat address is kept at the widest target width; each target takes its low bits,
  // which gives the per-target modulo wrap for free.
  localparam int AMAX = (IADDR_W > DADDR_W) ? ((IADDR_W > RADDR_W) ? IADDR_W : RADDR_W)
                                            : ((DADDR_W > RADDR_W) ? DADDR_W : RADDR_W);
  localparam int WCW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic op_is_err(input logic [2:0] op);
`ifdef DBG_DCACHE_WR_EN
    return (op > OP_DCWR);
`else
    return (op >= OP_DCWR);
`endif
  endfunction

  // Only legal reads honour cmd_len; everything else is a single beat.
  function automatic logic op_is_burst(input logic [2:0] op);
    return (op == OP_ICRD) || (op == OP_REGRD) || (op == OP_DCRD);
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [AMAX-1:0]      addr_q, addr_d;
  logic [BURST_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [IADDR_W-1:0]   icache_addr_q, icache_addr_d;
  logic                 icache_ceb_q, icache_ceb_d;
  logic                 icache_web_q, icache_web_d;
  logic [DATA_W-1:0]    icache_wdata_q, icache_wdata_d;
  logic [RADDR_W-1:0]   reg_raddr_q, reg_raddr_d;
  logic                 reg_read_q, reg_read_d;
  logic [DADDR_W-1:0]   dcache_addr_q, dcache_addr_d;
  logic                 dcache_ceb_q, dcache_ceb_d;
  logic                 busy_q, busy_d;
  logic                 issue;
`ifdef DBG_DCACHE_WR_EN
  logic [DATA_W-1:0]    dcache_bweb_q, dcache_bweb_d;
  logic [DATA_W-1:0]    dcache_wdata_q, dcache_wdata_d;
`endif

  logic unused_cmd_addr;
  assign unused_cmd_addr = ^cmd_addr[DATA_W-1:AMAX];

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    len_d          = len_q;
    wdata_d        = wdata_q;
    wait_cnt_d     = wait_cnt_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_last_d     = rsp_last_q;
    rsp_err_d      = rsp_err_q;
    icache_addr_d  = icache_addr_q;
    icache_wdata_d = icache_wdata_q;
    reg_raddr_d    = reg_raddr_q;
    dcache_addr_d  = dcache_addr_q;
    // Strobes default inactive so they are low for exactly the ISSUE cycle.
    icache_ceb_d   = 1'b1;
    icache_web_d   = 1'b1;
    dcache_ceb_d   = 1'b1;
    reg_read_d     = 1'b0;
`ifdef DBG_DCACHE_WR_EN
    dcache_bweb_d  = '1;
    dcache_wdata_d = dcache_wdata_q;
`endif
    issue          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          addr_d      = cmd_addr[AMAX-1:0];
          wdata_d     = cmd_wdata;
          len_d       = (op_is_burst(cmd_op) && !op_is_err(cmd_op)) ? cmd_len : '0;
          cmd_ready_d = 1'b0;
          state_d     = ISSUE;
          issue       = 1'b1;
        end
      end
      ISSUE: begin
        if (op_q == OP_ICRD || op_q == OP_DCRD) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(MEM_LAT - 1);
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (len_q == '0);
          rsp_err_d   = op_is_err(op_q);
          if (op_q == OP_PCRD)       rsp_data_d = pc_i;
          else if (op_q == OP_REGRD) rsp_data_d = reg_rdata_i;
          else                       rsp_data_d = '0;
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (len_q == '0);
          rsp_err_d   = 1'b0;
          rsp_data_d  = (op_q == OP_ICRD) ? icache_rdata_i : dcache_rdata_i;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          if (len_q != '0) begin
            len_d   = len_q - BURST_W'(1);
            addr_d  = addr_q + AMAX'(1);
            state_d = ISSUE;
            issue   = 1'b1;
          end else begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are launched on the edge that enters ISSUE, from the beat's op/address.
    if (issue) begin
      case (op_d)
        OP_ICRD: begin
          icache_ceb_d  = 1'b0;
          icache_addr_d = addr_d[IADDR_W-1:0];
        end
        OP_ICWR: begin
          icache_ceb_d   = 1'b0;
          icache_web_d   = 1'b0;
          icache_addr_d  = addr_d[IADDR_W-1:0];
          icache_wdata_d = wdata_d;
        end
        OP_REGRD: begin
          reg_read_d  = 1'b1;
          reg_raddr_d = addr_d[RADDR_W-1:0];
        end
        OP_DCRD: begin
          dcache_ceb_d  = 1'b0;
          dcache_addr_d = addr_d[DADDR_W-1:0];
        end
`ifdef DBG_DCACHE_WR_EN
        OP_DCWR: begin
          dcache_ceb_d   = 1'b0;
          dcache_bweb_d  = '0;
          dcache_addr_d  = addr_d[DADDR_W-1:0];
          dcache_wdata_d = wdata_d;
        end
`endif
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      wdata_q        <= '0;
      wait_cnt_q     <= '0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_last_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
      icache_addr_q  <= '0;
      icache_ceb_q   <= 1'b1;
      icache_web_q   <= 1'b1;
      icache_wdata_q <= '0;
      reg_raddr_q    <= '0;
      reg_read_q     <= 1'b0;
      dcache_addr_q  <= '0;
      dcache_ceb_q   <= 1'b1;
      busy_q         <= 1'b0;
`ifdef DBG_DCACHE_WR_EN
      dcache_bweb_q  <= '1;
      dcache_wdata_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      wdata_q        <= wdata_d;
      wait_cnt_q     <= wait_cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_last_q     <= rsp_last_d;
      rsp_err_q      <= rsp_err_d;
      icache_addr_q  <= icache_addr_d;
      icache_ceb_q   <= icache_ceb_d;
      icache_web_q   <= icache_web_d;
      icache_wdata_q <= icache_wdata_d;
      reg_raddr_q    <= reg_raddr_d;
      reg_read_q     <= reg_read_d;
      dcache_addr_q  <= dcache_addr_d;
      dcache_ceb_q   <= dcache_ceb_d;
      busy_q         <= busy_d;
`ifdef DBG_DCACHE_WR_EN
      dcache_bweb_q  <= dcache_bweb_d;
      dcache_wdata_q <= dcache_wdata_d;
`endif
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_last       = rsp_last_q;
  assign rsp_err        = rsp_err_q;
  assign icache_addr_o  = icache_addr_q;
  assign icache_ceb_o   = icache_ceb_q;
  assign icache_web_o   = icache_web_q;
  assign icache_wdata_o = icache_wdata_q;
  assign reg_raddr_o    = reg_raddr_q;
  assign reg_read_o     = reg_read_q;
  assign dcache_addr_o  = dcache_addr_q;
  assign dcache_ceb_o   = dcache_ceb_q;
  assign busy_o         = busy_q;
`ifdef DBG_DCACHE_WR_EN
  assign dcache_bweb_o  = dcache_bweb_q;
  assign dcache_wdata_o = dcache_wdata_q;
`else
  assign dcache_bweb_o  = '1;
  assign dcache_wdata_o = '0;
`endif

endmodule

// File: tb/tb_dbg_access_ctrl.sv
// tb/tb_dbg_access_ctrl.sv - directed self-checking bench for dbg_access_ctrl
module tb_dbg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_len;
  logic        rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] pc_i, icache_rdata_i, reg_rdata_i, dcache_rdata_i;
  logic [9:0]  icache_addr_o, dcache_addr_o;
  logic        icache_ceb_o, icache_web_o, dcache_ceb_o, reg_read_o, busy_o;
  logic [31:0] icache_wdata_o, dcache_bweb_o, dcache_wdata_o;
  logic [4:0]  reg_raddr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dbg_access_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .pc_i(pc_i), .icache_rdata_i(icache_rdata_i), .reg_rdata_i(reg_rdata_i),
    .dcache_rdata_i(dcache_rdata_i),
    .icache_addr_o(icache_addr_o), .icache_ceb_o(icache_ceb_o), .icache_web_o(icache_web_o),
    .icache_wdata_o(icache_wdata_o), .reg_raddr_o(reg_raddr_o), .reg_read_o(reg_read_o),
    .dcache_addr_o(dcache_addr_o), .dcache_ceb_o(dcache_ceb_o), .dcache_bweb_o(dcache_bweb_o),
    .dcache_wdata_o(dcache_wdata_o), .busy_o(busy_o)
  );

  // Two-stage SRAM stubs: address latched on the strobe edge, data one edge later.
  logic [31:0] ic_p1 = '0, dc_p1 = '0;
  initial begin
    icache_rdata_i = '0;
    dcache_rdata_i = '0;
  end
  always @(posedge clk) begin
    if (!icache_ceb_o) ic_p1 <= 32'hC0DE0000 | {22'd0, icache_addr_o};
    if (!dcache_ceb_o) dc_p1 <= 32'hDA7A0000 | {22'd0, dcache_addr_o};
    icache_rdata_i <= ic_p1;
    dcache_rdata_i <= dc_p1;
  end
  assign reg_rdata_i = 32'hAB000000 | {27'd0, reg_raddr_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the caller on the falling edge just after the accepting clock edge.
  task automatic send_cmd(input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] len, input logic [31:0] wdata);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int c = 0;
    while (rsp_valid !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, c, exp_lat);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [9:0]  ic_addr_tbl [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  logic [31:0] ic_data_tbl [4] = '{32'hC0DE03FE, 32'hC0DE03FF, 32'hC0DE0000, 32'hC0DE0001};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; pc_i = 32'h100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ic_ceb", icache_ceb_o, 1);
    check("rst_ic_web", icache_web_o, 1);
    check("rst_dc_bweb", dcache_bweb_o, 32'hFFFFFFFF);
    check("rst_reg_read", reg_read_o, 0);
    check("rst_busy", busy_o, 0);

    // ICWR: one-cycle write strobe, single beat with zero data.
    send_cmd(3'd2, 32'h3, 4'd2, 32'hDEADBEEF);
    check("icwr_ceb", icache_ceb_o, 0);
    check("icwr_web", icache_web_o, 0);
    check("icwr_addr", icache_addr_o, 3);
    check("icwr_wdata", icache_wdata_o, 32'hDEADBEEF);
    check("icwr_busy", busy_o, 1);
    wait_rsp("icwr_lat", 1);
    check("icwr_ceb_release", icache_ceb_o, 1);
    check("icwr_last", rsp_last, 1);
    check("icwr_err", rsp_err, 0);
    check("icwr_data", rsp_data, 0);
    consume();

    // ICRD burst with wrap at the top of the icache.
    send_cmd(3'd1, 32'h3FE, 4'd3, 32'h0);
    for (int b = 0; b < 4; b++) begin
      check("icrd_ceb", icache_ceb_o, 0);
      check("icrd_web", icache_web_o, 1);
      check("icrd_addr", icache_addr_o, ic_addr_tbl[b]);
      wait_rsp("icrd_lat", 3);
      check("icrd_data", rsp_data, ic_data_tbl[b]);
      check("icrd_last", rsp_last, (b == 3) ? 1 : 0);
      consume();
    end
    check("icrd_done_ready", cmd_ready, 1);

    // REGRD held off by rsp_ready; stray cmd_valid must be ignored meanwhile.
    send_cmd(3'd3, 32'h5, 4'd0, 32'h0);
    check("regrd_read", reg_read_o, 1);
    check("regrd_raddr", reg_raddr_o, 5);
    wait_rsp("regrd_lat", 1);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 32'h9;
    for (int i = 0; i < 4; i++) begin
      check("regrd_hold_valid", rsp_valid, 1);
      check("regrd_hold_data", rsp_data, 32'hAB000005);
      check("regrd_hold_last", rsp_last, 1);
      check("regrd_no_strobe", {reg_read_o, icache_ceb_o}, 2'b01);
      check("regrd_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    consume();

    // DCWR: behaviour depends on the build option.
    send_cmd(3'd5, 32'h7, 4'd0, 32'h12345678);
`ifdef DBG_DCACHE_WR_EN
    check("dcwr_ceb", dcache_ceb_o, 0);
    check("dcwr_bweb", dcache_bweb_o, 32'h0);
    check("dcwr_addr", dcache_addr_o, 7);
    check("dcwr_wdata", dcache_wdata_o, 32'h12345678);
    wait_rsp("dcwr_lat", 1);
    check("dcwr_bweb_release", dcache_bweb_o, 32'hFFFFFFFF);
    check("dcwr_err", rsp_err, 0);
`else
    check("dcwr_ceb", dcache_ceb_o, 1);
    check("dcwr_bweb", dcache_bweb_o, 32'hFFFFFFFF);
    check("dcwr_wdata", dcache_wdata_o, 0);
    wait_rsp("dcwr_lat", 1);
    check("dcwr_err", rsp_err, 1);
`endif
    check("dcwr_last", rsp_last, 1);
    check("dcwr_data", rsp_data, 0);
    consume();

    // Illegal op 7 with a non-zero length.
    send_cmd(3'd7, 32'h1, 4'd3, 32'h0);
    check("ill_strobes", {icache_ceb_o, icache_web_o, dcache_ceb_o, reg_read_o}, 4'b1110);
    wait_rsp("ill_lat", 1);
    check("ill_err", rsp_err, 1);
    check("ill_last", rsp_last, 1);
    check("ill_data", rsp_data, 0);
    consume();
    check("ill_single_beat", rsp_valid, 0);

    // PCRD ignores cmd_len.
    send_cmd(3'd0, 32'h0, 4'd3, 32'h0);
    wait_rsp("pcrd_lat", 1);
    check("pcrd_data", rsp_data, 32'h100);
    check("pcrd_last", rsp_last, 1);
    check("pcrd_err", rsp_err, 0);
    consume();
    check("pcrd_idle", busy_o, 0);

    // Reset during beat 2 of a 6-beat DCRD.
    send_cmd(3'd4, 32'h10, 4'd5, 32'h0);
    wait_rsp("dcrd_lat", 3);
    check("dcrd_b1_data", rsp_data, 32'hDA7A0010);
    check("dcrd_b1_last", rsp_last, 0);
    consume();
    check("dcrd_b2_ceb", dcache_ceb_o, 0);
    check("dcrd_b2_addr", dcache_addr_o, 10'h011);
    rst_n = 1'b0;
    #1;
    check("arst_ceb", dcache_ceb_o, 1);
    check("arst_addr", dcache_addr_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("arst_no_rsp", rsp_valid, 0);
    end
    send_cmd(3'd4, 32'h20, 4'd0, 32'h0);
    check("dcrd2_ceb", dcache_ceb_o, 0);
    wait_rsp("dcrd2_lat", 3);
    check("dcrd2_data", rsp_data, 32'hDA7A0020);
    check("dcrd2_last", rsp_last, 1);
    consume();
    check("dcrd2_idle", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
